// File: rtl/rx_byte_fifo_if.sv
// Bundles the receive-core handshake and the host read port of rx_byte_fifo.
// The slave modport is the buffer itself. The master modport is whatever sits
// around it: the receive core plus the host.
interface rx_byte_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    // Receive-core side
    logic [7:0]          rxData;
    logic                rxDataReady;
    logic                rxFrameError;
    logic                rxOverrun;
    logic                ackFlags;

    // Host side
    logic                pop;
    logic                flush;
    logic                clearErrors;
    logic [7:0]          rdData;
    logic                rdFrameError;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                fifoOverflow;
    logic                overrunSeen;

    modport slave (
        input  rxData, rxDataReady, rxFrameError, rxOverrun,
        output ackFlags,
        input  pop, flush, clearErrors,
        output rdData, rdFrameError, empty, full, count,
        output fifoOverflow, overrunSeen
    );

    modport master (
        output rxData, rxDataReady, rxFrameError, rxOverrun,
        input  ackFlags,
        output pop, flush, clearErrors,
        input  rdData, rdFrameError, empty, full, count,
        input  fifoOverflow, overrunSeen
    );
endinterface

// File: rtl/rx_byte_fifo.sv
// Receive-side character buffer for the ISO7816 receive core.
// Each character the core flags (ready or frame error) is captured once into a
// show-ahead FIFO entry {frameError, data}. The FIFO then acknowledges the core
// until the core drops its flags. Sticky overflow and overrun indications are
// kept for the host.
module rx_byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic           clk,
    input  logic           nReset,
    rx_byte_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } captureState_t;

    captureState_t         stateReg;
    captureState_t         stateNext;
    logic                  captureReq;

    logic [8:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtrReg;
    logic [DEPTH_LOG2-1:0] rdPtrReg;
    logic [DEPTH_LOG2:0]   countReg;
    logic                  fifoOverflowReg;
    logic                  overrunSeenReg;

    logic                  rxFlag;
    logic                  emptyInt;
    logic                  fullInt;
    logic                  popAccept;
    logic                  pushAccept;
    logic                  dropChar;
    logic [8:0]            wrEntry;
    logic [8:0]            headEntry;

    // Any flag raised by the core counts as a character to take.
    assign rxFlag   = bus.rxDataReady | bus.rxFrameError;

    assign emptyInt = (countReg == '0);
    assign fullInt  = (countReg == FULL_COUNT);

    // A pop on an empty FIFO is silently ignored.
    assign popAccept = bus.pop & ~emptyInt;

    // A full FIFO still accepts a character when the host frees the head
    // slot in the same cycle. Flush always discards the incoming character.
    assign pushAccept = captureReq & (~fullInt | popAccept) & ~bus.flush;
    assign dropChar   = captureReq & fullInt & ~popAccept;

    // If the core ever raises ready and error together, ready wins and the
    // entry is stored as good data.
    assign wrEntry = {bus.rxFrameError & ~bus.rxDataReady, bus.rxData};

    // Capture FSM state register; reset mid-acknowledge returns to IDLE.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Capture FSM next state. A character is taken only on the IDLE to ACK
    // step. Flags that re-assert during ACK are acknowledged but not stored.
    always_comb begin
        stateNext  = stateReg;
        captureReq = 1'b0;
        case (stateReg)
            IDLE: begin
                if (rxFlag) begin
                    captureReq = 1'b1;
                    stateNext  = ACK;
                end
            end
            ACK: begin
                if (!rxFlag) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // The acknowledge comes straight from the state register, so it is glitch-free.
    assign bus.ackFlags = (stateReg == ACK);

    // Entry storage. It is not reset because contents only matter while the FIFO is not empty.
    always_ff @(posedge clk) begin
        if (pushAccept) begin
            mem[wrPtrReg] <= wrEntry;
        end
    end

    // Pointers and occupancy. Flush overrides both push and pop.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else if (bus.flush) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (pushAccept) begin
                wrPtrReg <= wrPtrReg + PTR_ONE;
            end
            if (popAccept) begin
                rdPtrReg <= rdPtrReg + PTR_ONE;
            end
            case ({pushAccept, popAccept})
                2'b10:   countReg <= countReg + COUNT_ONE;
                2'b01:   countReg <= countReg - COUNT_ONE;
                default: countReg <= countReg;
            endcase
        end
    end

    // Sticky error flags. A set event in the same cycle beats a clear.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            fifoOverflowReg <= 1'b0;
            overrunSeenReg  <= 1'b0;
        end else begin
            if (dropChar) begin
                fifoOverflowReg <= 1'b1;
            end else if (bus.clearErrors) begin
                fifoOverflowReg <= 1'b0;
            end
            if (bus.rxOverrun) begin
                overrunSeenReg <= 1'b1;
            end else if (bus.clearErrors) begin
                overrunSeenReg <= 1'b0;
            end
        end
    end

    // Show-ahead read port: the head entry is always on the outputs.
    assign headEntry        = mem[rdPtrReg];
    assign bus.rdData       = headEntry[7:0];
    assign bus.rdFrameError = headEntry[8];

    assign bus.empty        = emptyInt;
    assign bus.full         = fullInt;
    assign bus.count        = countReg;
    assign bus.fifoOverflow = fifoOverflowReg;
    assign bus.overrunSeen  = overrunSeenReg;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed bench for rx_byte_fifo with a four-entry FIFO.
// It drives inputs on falling edges and samples outputs on falling edges.
module tb_rx_byte_fifo;
    localparam int DEPTH_LOG2 = 2;

    logic clk;
    logic nReset;
    int   testsRun;
    int   testsFailed;
    int   ackCycles;

    rx_byte_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    rx_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, observed);
        end
    endtask

    // Act as the receive core: raise a flag with data, hold it until ackFlags
    // is seen, then drop it. Returns how many sampled cycles ackFlags was high.
    task automatic sendChar(input logic [7:0] d, input logic isErr, output int acks);
        bit seen;
        acks = 0;
        seen = 0;
        @(negedge clk);
        bus.rxData       = d;
        bus.rxDataReady  = ~isErr;
        bus.rxFrameError = isErr;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (bus.ackFlags) seen = 1;
        end
        if (!seen) checkVal("ackTimeout", 0, 1);
        bus.rxDataReady  = 1'b0;
        bus.rxFrameError = 1'b0;
        if (seen) begin
            acks = 1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (!bus.ackFlags) break;
                acks++;
            end
        end
    endtask

    task automatic popOne();
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
    endtask

    task automatic pulseClear();
        bus.clearErrors = 1'b1;
        @(negedge clk);
        bus.clearErrors = 1'b0;
    endtask

    initial begin
        logic [7:0] expData;
        testsRun    = 0;
        testsFailed = 0;
        nReset           = 1'b0;
        bus.rxData       = 8'h00;
        bus.rxDataReady  = 1'b0;
        bus.rxFrameError = 1'b0;
        bus.rxOverrun    = 1'b0;
        bus.pop          = 1'b0;
        bus.flush        = 1'b0;
        bus.clearErrors  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        checkVal("rst.ack",   bus.ackFlags, 0);
        checkVal("rst.empty", bus.empty, 1);
        checkVal("rst.full",  bus.full, 0);
        checkVal("rst.count", bus.count, 0);
        checkVal("rst.ovf",   bus.fifoOverflow, 0);
        checkVal("rst.ovr",   bus.overrunSeen, 0);
        nReset = 1'b1;
        @(negedge clk);

        // 1: good character
        sendChar(8'h3B, 1'b0, ackCycles);
        checkVal("t1.ackCycles", ackCycles, 1);
        checkVal("t1.count",     bus.count, 1);
        checkVal("t1.rdData",    bus.rdData, 8'h3B);
        checkVal("t1.rdErr",     bus.rdFrameError, 0);
        popOne();
        checkVal("t1.emptyAfterPop", bus.empty, 1);
        popOne();
        checkVal("t1.popEmptyCount", bus.count, 0);

        // 2: frame error character
        sendChar(8'hA5, 1'b1, ackCycles);
        checkVal("t2.ackCycles", ackCycles, 1);
        checkVal("t2.ackLow",    bus.ackFlags, 0);
        checkVal("t2.rdData",    bus.rdData, 8'hA5);
        checkVal("t2.rdErr",     bus.rdFrameError, 1);
        popOne();

        // 3: overflow, fifth character lost
        for (int i = 1; i <= 5; i++) sendChar(8'(i), 1'b0, ackCycles);
        checkVal("t3.full",  bus.full, 1);
        checkVal("t3.count", bus.count, 4);
        checkVal("t3.ovf",   bus.fifoOverflow, 1);
        for (int i = 1; i <= 4; i++) begin
            checkVal($sformatf("t3.pop%0d", i), bus.rdData, i);
            popOne();
        end
        checkVal("t3.empty", bus.empty, 1);

        // 4: push and pop while full, across pointer wrap
        pulseClear();
        checkVal("t4.ovfCleared", bus.fifoOverflow, 0);
        for (int i = 0; i < 4; i++) sendChar(8'h10 + 8'(i), 1'b0, ackCycles);
        checkVal("t4.fullBefore", bus.full, 1);
        bus.rxData      = 8'h14;
        bus.rxDataReady = 1'b1;
        bus.pop         = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
        checkVal("t4.ackHigh", bus.ackFlags, 1);
        bus.rxDataReady = 1'b0;
        checkVal("t4.count", bus.count, 4);
        checkVal("t4.ovf",   bus.fifoOverflow, 0);
        @(negedge clk);
        checkVal("t4.ackLow", bus.ackFlags, 0);
        for (int i = 1; i <= 4; i++) begin
            expData = 8'h10 + 8'(i);
            checkVal($sformatf("t4.pop%0d", i), bus.rdData, expData);
            popOne();
        end
        checkVal("t4.empty", bus.empty, 1);

        // 5: sticky flags
        bus.rxOverrun = 1'b1;
        @(negedge clk);
        bus.rxOverrun = 1'b0;
        checkVal("t5.ovr", bus.overrunSeen, 1);
        pulseClear();
        checkVal("t5.ovrCleared", bus.overrunSeen, 0);
        checkVal("t5.ovfCleared", bus.fifoOverflow, 0);
        for (int i = 0; i < 4; i++) sendChar(8'h20 + 8'(i), 1'b0, ackCycles);
        bus.rxData      = 8'h24;
        bus.rxDataReady = 1'b1;
        bus.clearErrors = 1'b1;
        @(negedge clk);
        bus.clearErrors = 1'b0;
        bus.rxDataReady = 1'b0;
        checkVal("t5.ovfWins", bus.fifoOverflow, 1);
        checkVal("t5.count",   bus.count, 4);
        @(negedge clk);

        // flush empties the FIFO
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checkVal("flush.count", bus.count, 0);
        checkVal("flush.empty", bus.empty, 1);

        // 6: reset during ACK with the flag still high
        bus.rxOverrun = 1'b1;
        @(negedge clk);
        bus.rxOverrun   = 1'b0;
        bus.rxData      = 8'h5A;
        bus.rxDataReady = 1'b1;
        @(negedge clk);
        checkVal("t6.ackBefore", bus.ackFlags, 1);
        nReset = 1'b0;
        #1;
        checkVal("t6.rstAck",   bus.ackFlags, 0);
        checkVal("t6.rstCount", bus.count, 0);
        checkVal("t6.rstEmpty", bus.empty, 1);
        checkVal("t6.rstFull",  bus.full, 0);
        checkVal("t6.rstOvf",   bus.fifoOverflow, 0);
        checkVal("t6.rstOvr",   bus.overrunSeen, 0);
        @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);
        checkVal("t6.ackAfter", bus.ackFlags, 1);
        bus.rxDataReady = 1'b0;
        checkVal("t6.count",  bus.count, 1);
        checkVal("t6.rdData", bus.rdData, 8'h5A);
        @(negedge clk);
        checkVal("t6.ackLow",     bus.ackFlags, 0);
        checkVal("t6.countFinal", bus.count, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/rx_byte_fifo.md
# rx_byte_fifo

Receive-side buffer sitting directly downstream of the ISO7816 receive core. It watches the core's data-ready and frame-error flags, stores each received character with its error status in a FIFO, and returns `ackFlags` so the core can accept the next character. It also latches sticky overflow and overrun indications for the host. The host side reads from a show-ahead FIFO interface.

## Interface

**Parameters**
- `DEPTH_LOG2`, default 4: the FIFO holds 2^DEPTH_LOG2 entries.

**Ports**
- `clk` in 1: system clock.
- `nReset` in 1: asynchronous, active-low reset.
- `rxData` in 8: character from the receive core (`dataOut`).
- `rxDataReady` in 1: core `dataOutReadyFlag`.
- `rxFrameError` in 1: core `frameErrorFlag`.
- `rxOverrun` in 1: core `overrunErrorFlag`.
- `ackFlags` out 1: to the core; clears its ready and frame-error flags.
- `pop` in 1: host consumes the head entry.
- `flush` in 1: synchronous FIFO empty.
- `clearErrors` in 1: clears the sticky flags.
- `rdData` out 8: head entry data.
- `rdFrameError` out 1: head entry error bit.
- `empty` out 1: FIFO is empty.
- `full` out 1: FIFO is full.
- `count` out DEPTH_LOG2+1: number of stored entries.
- `fifoOverflow` out 1: sticky; a character was dropped because the FIFO was full.
- `overrunSeen` out 1: sticky; `rxOverrun` was observed high.

## Operation

**Storage**
- Entries are 9 bits: {frameError, data[7:0]}.
- Read and write pointers are DEPTH_LOG2 bits and wrap modulo the depth.
- `count` ranges 0..2^DEPTH_LOG2.
- `empty` = (count==0). `full` = (count==2^DEPTH_LOG2).

**Capture FSM**
- IDLE:
  - If `rxDataReady | rxFrameError`:
    - If not full, write {rxFrameError & ~rxDataReady, rxData}.
    - If full, set `fifoOverflow` and write nothing.
    - Go to ACK.
- ACK:
  - `ackFlags`=1 (registered, decoded from state).
  - Stay while `rxDataReady | rxFrameError`.
  - Return to IDLE the first cycle both are low.
- Capture happens exactly once per IDLE→ACK transition. A flag that re-asserts while in ACK is cleared by the core without being captured. This behaviour is intended.
- If ready and error are both high, the ready flag wins and the error bit is 0. The core never does this legitimately.

**Read side**
- `rdData`/`rdFrameError` always present mem[rdPtr]. They are valid only when `~empty`.
- `pop & ~empty` advances rdPtr at the clock edge. `pop` when empty is ignored and has no other effect.

**Simultaneous events**
- Push and pop in the same cycle: both pointers advance and `count` is unchanged.
- Push when full with pop in the same cycle: the push is accepted (pop frees the slot) and no overflow is flagged.
- `flush` has priority over push and pop. Pointers and count go to 0. A push in the same cycle is discarded. FSM state is unaffected.
- `overrunSeen` is set in any cycle `rxOverrun`=1.
- `clearErrors` clears `fifoOverflow` and `overrunSeen`. A set condition in the same cycle wins.

**Reset**
- Reset state: FSM IDLE, pointers 0, `count`=0, `empty`=1, `full`=0, `ackFlags`=0, `fifoOverflow`=0, `overrunSeen`=0.
- `rdData`/`rdFrameError` are undefined while empty; memory is not reset.
- Reset during ACK returns to IDLE. Flags still high after reset are captured again as a new character.

## Timing

- Flag high in IDLE at cycle N:
  - Entry written at the end of N; `count`/`empty` update in N+1.
  - `ackFlags`=1 from N+1.
  - The core clears its flags at the end of N+1, so they are low in N+2.
  - FSM returns to IDLE at the end of N+2; `ackFlags`=0 in N+3.
  - Minimum spacing between captures is 3 cycles. This is far below the character time.
- Pop latency: the new head is visible the cycle after the `pop` edge.
- Sticky flags: set visible the cycle after the event.

## Test plan

1. Ready pulse with rxData=0x3B (held until ack) → `ackFlags` high for 1 cycle; `count`=1; `rdData`=0x3B, `rdFrameError`=0; pop → `empty`=1.
2. Frame error with rxData=0xA5 → entry {1,0xA5}; `ackFlags` asserted and released once the flag clears.
3. DEPTH_LOG2=2: push 5 characters 0x01..0x05 without popping → `full`=1, `count`=4, `fifoOverflow`=1. Pops read 0x01..0x04; 0x05 is lost.
4. Full FIFO with push and pop in the same cycle → `count` stays 4; no overflow; order preserved across pointer wrap.
5. `rxOverrun` pulse → `overrunSeen`=1. `clearErrors` → both sticky flags 0. `clearErrors` concurrent with an overflowing push → `fifoOverflow`=1.
6. `nReset` asserted mid-ACK with the flag still high → outputs at reset values; after release the character is captured once; `count`=1.
